// File: rtl/uop_sequencer.sv
// uop_sequencer: expands one 16-bit instruction into a sequence of micro-ops.
//   CALL  -> PUSH_PC, JUMP
//   PUSHM -> PUSH per set mask bit, highest pair first (pre-decrement)
//   POPM  -> POP per set mask bit, lowest pair first (post-increment)
//   other -> single PASS
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   inst_valid, inst, inst_done     instruction intake handshake
//   flush                           abort current sequence
//   uop_valid, uop_done             micro-op issue handshake
//   uop_kind/reg/predec/src_pc/last/index/inst   presented micro-op fields
module uop_sequencer #(
  parameter int unsigned LOG2_NR  = 3,
  parameter int unsigned CNT_BITS = $clog2((1 << (LOG2_NR - 1)) + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inst_valid,
  input  logic [15:0]         inst,
  output logic                inst_done,
  input  logic                flush,
  output logic                uop_valid,
  input  logic                uop_done,
  output logic [2:0]          uop_kind,
  output logic [LOG2_NR-1:0]  uop_reg,
  output logic                uop_predec,
  output logic                uop_src_pc,
  output logic                uop_last,
  output logic [CNT_BITS-1:0] uop_index,
  output logic [15:0]         uop_inst
);

  localparam int unsigned NPAIRS = 1 << (LOG2_NR - 1);
  localparam int unsigned SEL_W  = LOG2_NR - 1;

  localparam logic [2:0] K_PASS    = 3'd0;
  localparam logic [2:0] K_PUSH_PC = 3'd1;
  localparam logic [2:0] K_JUMP    = 3'd2;
  localparam logic [2:0] K_PUSH    = 3'd3;
  localparam logic [2:0] K_POP     = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EMPTY} state_e;
  typedef enum logic [1:0] {CLS_PASS, CLS_CALL, CLS_PUSHM, CLS_POPM} cls_e;

  state_e              state, state_nxt;
  cls_e                cls, in_cls;
  logic [NPAIRS-1:0]   rem;
  logic [NPAIRS-1:0]   in_mask;
  logic [CNT_BITS-1:0] idx;
  logic [SEL_W-1:0]    sel_hi, sel_lo, sel;
  logic                rem_one;
  logic                last_c;
  logic                accept;
  logic                advance;

  // Classify the incoming instruction word
  always_comb begin
    in_cls  = CLS_PASS;
    in_mask = inst[NPAIRS-1:0];
    if (inst[15:6] == 10'b0010000001) begin
      in_cls = CLS_CALL;
    end else if (inst[15:8] == 8'b00001111) begin
      in_cls = inst[7] ? CLS_POPM : CLS_PUSHM;
    end
  end

  // Priority encoders over the remaining mask; rem_one = exactly one bit left
  always_comb begin
    sel_hi = '0;
    sel_lo = '0;
    for (int i = 0; i < NPAIRS; i++) begin
      if (rem[i]) sel_hi = SEL_W'(i);
    end
    for (int i = NPAIRS - 1; i >= 0; i--) begin
      if (rem[i]) sel_lo = SEL_W'(i);
    end
    sel     = (cls == CLS_PUSHM) ? sel_hi : sel_lo;
    rem_one = (rem != '0) && ((rem & (rem - NPAIRS'(1))) == '0);
    case (cls)
      CLS_CALL:  last_c = (idx == CNT_BITS'(1));
      CLS_PUSHM,
      CLS_POPM:  last_c = rem_one;
      default:   last_c = 1'b1;
    endcase
  end

  assign accept  = (state == S_IDLE) && inst_valid && !flush;
  assign advance = (state == S_ISSUE) && uop_done && !flush && !last_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (inst_valid) begin
          state_nxt = ((in_cls == CLS_PUSHM || in_cls == CLS_POPM) && in_mask == '0)
                      ? S_EMPTY : S_ISSUE;
        end
      end
      S_ISSUE: if (uop_done && last_c) state_nxt = S_IDLE;
      S_EMPTY: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Latched instruction, class, remaining mask and micro-op index
  always_ff @(posedge clk) begin
    if (reset) begin
      uop_inst <= '0;
      cls      <= CLS_PASS;
      rem      <= '0;
      idx      <= '0;
    end else if (accept) begin
      uop_inst <= inst;
      cls      <= in_cls;
      rem      <= (in_cls == CLS_PUSHM || in_cls == CLS_POPM) ? in_mask : '0;
      idx      <= '0;
    end else if (advance) begin
      idx <= idx + CNT_BITS'(1);
      if (cls == CLS_PUSHM || cls == CLS_POPM) begin
        rem <= rem & ~(NPAIRS'(1) << sel);
      end
    end
  end

  // Output decode from registered state
  always_comb begin
    uop_valid  = 1'b0;
    inst_done  = 1'b0;
    uop_kind   = K_PASS;
    uop_reg    = '0;
    uop_predec = 1'b0;
    uop_src_pc = 1'b0;
    uop_last   = 1'b0;
    uop_index  = '0;
    case (state)
      S_ISSUE: begin
        uop_valid = 1'b1;
        uop_last  = last_c;
        uop_index = idx;
        inst_done = uop_done && last_c && !flush;
        case (cls)
          CLS_CALL: begin
            if (idx == '0) begin
              uop_kind   = K_PUSH_PC;
              uop_predec = 1'b1;
              uop_src_pc = 1'b1;
            end else begin
              uop_kind = K_JUMP;
            end
          end
          CLS_PUSHM: begin
            uop_kind   = K_PUSH;
            uop_reg    = {sel, 1'b0};
            uop_predec = 1'b1;
          end
          CLS_POPM: begin
            uop_kind = K_POP;
            uop_reg  = {sel, 1'b0};
          end
          default: uop_kind = K_PASS;
        endcase
      end
      S_EMPTY: inst_done = !flush;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Scoreboard bench for uop_sequencer (default parameters: 4 pairs).
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        reset, inst_valid, flush, uop_done;
  logic [15:0] inst;
  logic        inst_done, uop_valid, uop_predec, uop_src_pc, uop_last;
  logic [2:0]  uop_kind, uop_reg, uop_index;
  logic [15:0] uop_inst;

  typedef struct packed {
    logic [2:0]  kind;
    logic [2:0]  rg;
    logic        predec;
    logic        src_pc;
    logic        last;
    logic [2:0]  idx;
    logic [15:0] inst;
  } uop_t;

  uop_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;

  uop_sequencer dut (
    .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst(inst),
    .inst_done(inst_done), .flush(flush), .uop_valid(uop_valid),
    .uop_done(uop_done), .uop_kind(uop_kind), .uop_reg(uop_reg),
    .uop_predec(uop_predec), .uop_src_pc(uop_src_pc), .uop_last(uop_last),
    .uop_index(uop_index), .uop_inst(uop_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference expansion of one instruction into expected micro-ops
  task automatic model(input logic [15:0] w, output int n);
    uop_t e;
    int   cnt, k;
    n = 0;
    if (w[15:6] == 10'b0010000001) begin
      e = '{kind: 3'd1, rg: 3'd0, predec: 1'b1, src_pc: 1'b1, last: 1'b0, idx: 3'd0, inst: w};
      exp_q.push_back(e);
      e = '{kind: 3'd2, rg: 3'd0, predec: 1'b0, src_pc: 1'b0, last: 1'b1, idx: 3'd1, inst: w};
      exp_q.push_back(e);
      n = 2;
    end else if (w[15:8] == 8'h0F) begin
      cnt = 0;
      for (int p = 0; p < 4; p++) if (w[p]) cnt++;
      k = 0;
      for (int j = 0; j < 4; j++) begin
        int p;
        p = w[7] ? j : 3 - j;
        if (w[p]) begin
          e = '{kind: (w[7] ? 3'd4 : 3'd3), rg: 3'(2 * p), predec: !w[7], src_pc: 1'b0,
                last: (k == cnt - 1), idx: 3'(k), inst: w};
          exp_q.push_back(e);
          k++;
        end
      end
      n = cnt;
    end else begin
      e = '{kind: 3'd0, rg: 3'd0, predec: 1'b0, src_pc: 1'b0, last: 1'b1, idx: 3'd0, inst: w};
      exp_q.push_back(e);
      n = 1;
    end
  endtask

  // Compare each completed micro-op against the scoreboard; count inst_done pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_done) done_cnt++;
      if (uop_valid && uop_done) begin
        if (exp_q.size() == 0) begin
          chk("uop_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          uop_t e;
          e = exp_q.pop_front();
          chk("uop", 32'({uop_kind, uop_reg, uop_predec, uop_src_pc, uop_last, uop_index, uop_inst}),
              32'(e));
          chk("inst_done", 32'(inst_done), 32'(e.last));
        end
      end
    end
  end

  // Drive one instruction; optionally abort at micro-op abort_at via flush or reset
  task automatic send(input logic [15:0] w, input int lat, input int abort_at, input bit abort_rst);
    int n, issued, done0;
    bit aborted;
    model(w, n);
    done0   = done_cnt;
    issued  = 0;
    aborted = 1'b0;
    inst_valid = 1'b1;
    inst       = w;
    @(posedge clk); #1;
    if (n == 0) begin
      @(negedge clk);
      chk("empty_valid", 32'(uop_valid), 32'd0);
      chk("empty_done", 32'(inst_done), 32'd1);
      @(posedge clk); #1;
      inst_valid = 1'b0;
      @(negedge clk); #1;
      chk("empty_after", 32'(inst_done), 32'd0);
      chk("empty_count", 32'(done_cnt - done0), 32'd1);
      return;
    end
    while (issued < n && !aborted) begin
      for (int k = 0; k < lat; k++) begin
        @(negedge clk);
        chk("valid_wait", 32'(uop_valid), 32'd1);
        @(posedge clk); #1;
      end
      if (issued == abort_at) begin
        aborted = 1'b1;
        if (abort_rst) reset = 1'b1;
        else begin
          flush    = 1'b1;
          uop_done = 1'b1;
        end
      end else begin
        uop_done = 1'b1;
      end
      @(negedge clk);
      chk("valid", 32'(uop_valid), 32'd1);
      @(posedge clk); #1;
      uop_done = 1'b0;
      flush    = 1'b0;
      reset    = 1'b0;
      issued++;
    end
    inst_valid = 1'b0;
    if (aborted) begin
      chk("abort_left", 32'(exp_q.size()), 32'(n - issued + (abort_rst ? 1 : 0)));
      exp_q.delete();
    end else begin
      chk("q_empty", 32'(exp_q.size()), 32'd0);
    end
    @(negedge clk); #1;
    if (abort_rst) begin
      chk("rst_outs", 32'({uop_valid, inst_done, uop_kind, uop_reg, uop_predec, uop_src_pc,
                           uop_last, uop_index, uop_inst}), 32'd0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("rst_stay_idle", 32'(uop_valid), 32'd0);
      end
    end else begin
      chk("idle_fields", 32'({uop_valid, uop_kind, uop_reg, uop_predec, uop_src_pc,
                              uop_last, uop_index}), 32'd0);
      chk("idle_inst", 32'(uop_inst), 32'(w));
    end
    chk("done_count", 32'(done_cnt - done0), aborted ? 32'd0 : 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; inst_valid = 1'b0; inst = '0; flush = 1'b0; uop_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_outs", 32'({uop_valid, inst_done, uop_kind, uop_reg, uop_predec, uop_src_pc,
                           uop_last, uop_index, uop_inst}), 32'd0);
    @(posedge clk); #1;

    send(16'h8A45, 3, -1, 1'b0);  // PASS, 3-cycle scheduler latency
    send(16'h2047, 1, -1, 1'b0);  // CALL
    send(16'h0F0B, 0, -1, 1'b0);  // pushm 6,2,0 back-to-back
    send(16'h0F8B, 2, -1, 1'b0);  // popm 0,2,6
    send(16'h0F00, 0, -1, 1'b0);  // empty mask
    send(16'h0F0F, 0,  1, 1'b0);  // flush on second PUSH
    send(16'h8A45, 0, -1, 1'b0);  // normal after flush
    send(16'h0F8B, 1,  1, 1'b1);  // reset mid-popm
    send(16'h8A45, 0, -1, 1'b0);  // normal after reset
    send(16'h0F8F, 0, -1, 1'b0);  // popm full mask, one per cycle
    send(16'h0F01, 1, -1, 1'b0);  // pushm single pair 0
    send(16'h0F76, 0, -1, 1'b0);  // pushm, ignored bits set, pairs 2,1

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
